// File: rtl/conv_postproc_pipe.sv
// conv_postproc_pipe: post-processing for conv-layer accumulators.
// Each lane gets a per-channel bias add, optional ReLU, per-channel scale multiply,
// a round-half-up arithmetic right shift and saturation to signed OUT_W.
// The pipeline has three registered stages with valid/ready backpressure on both sides.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cfg_we/cfg_sel/cfg_ch/cfg_data     config table write (0=bias, 1=scale, 2=shift)
//   relu_en                            per-beat ReLU enable, captured at acceptance
//   in_valid/in_ready/in_ch/in_acc     input beat (LANES signed ACC_W accumulators)
//   out_valid/out_ready/out_ch         output beat handshake and channel tag
//   out_data/out_sat                   LANES signed OUT_W results, any-lane-saturated flag
module conv_postproc_pipe #(
    parameter int unsigned LANES   = 40,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned BIAS_W  = 16,
    parameter int unsigned SCALE_W = 16,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned NCH     = 32,
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [15:0]            cfg_data,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH_W-1:0]        in_ch,
    input  logic [LANES*ACC_W-1:0] in_acc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_sat
);

    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned PROD_W = ACC_W + SCALE_W + 2;

    localparam logic signed [PROD_W-1:0] OUT_MAX = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] OUT_MIN = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Per-channel config tables
    logic signed [BIAS_W-1:0]  bias_q  [NCH];
    logic        [SCALE_W-1:0] scale_q [NCH];
    logic        [SHIFT_W-1:0] shift_q [NCH];
    logic                      cfg_ch_ok;

    if (NCH == (2 ** CH_W)) begin : g_ch_full
        assign cfg_ch_ok = 1'b1;
    end else begin : g_ch_part
        assign cfg_ch_ok = (32'(cfg_ch) < NCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                bias_q[c]  <= '0;
                scale_q[c] <= SCALE_W'(1);
                shift_q[c] <= '0;
            end
        end else if (cfg_we && cfg_ch_ok) begin
            case (cfg_sel)
                2'd0:    bias_q[cfg_ch]  <= cfg_data[BIAS_W-1:0];
                2'd1:    scale_q[cfg_ch] <= cfg_data[SCALE_W-1:0];
                2'd2:    shift_q[cfg_ch] <= cfg_data[SHIFT_W-1:0];
                default: ;
            endcase
        end
    end

    // Handshake chain: a stage may load when empty or when it is being drained this cycle.
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_load, s2_load, s3_load;

    assign s3_load  = s2_valid_q && (!s3_valid_q || out_ready);
    assign s2_load  = s1_valid_q && (!s2_valid_q || s3_load);
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_load  = in_valid && in_ready;

    // Stage 1: bias add, config captured with the beat
    logic signed [SUM_W-1:0]   s1_sum_d [LANES];
    logic signed [SUM_W-1:0]   s1_sum_q [LANES];
    logic [CH_W-1:0]           s1_ch_q;
    logic                      s1_relu_q;
    logic [SCALE_W-1:0]        s1_scale_q;
    logic [SHIFT_W-1:0]        s1_shift_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_sum_d[i] = SUM_W'($signed(in_acc[i*ACC_W +: ACC_W])) + SUM_W'(bias_q[in_ch]);
        end
    end

    // Stage 2: ReLU and scale multiply
    logic signed [SUM_W-1:0]   s2_relu  [LANES];
    logic signed [PROD_W-1:0]  s2_prod_d [LANES];
    logic signed [PROD_W-1:0]  s2_prod_q [LANES];
    logic [CH_W-1:0]           s2_ch_q;
    logic [SHIFT_W-1:0]        s2_shift_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s2_relu[i]   = (s1_relu_q && s1_sum_q[i][SUM_W-1]) ? '0 : s1_sum_q[i];
            s2_prod_d[i] = PROD_W'(s2_relu[i]) * PROD_W'($signed({1'b0, s1_scale_q}));
        end
    end

    // Stage 3: round half up, arithmetic shift, clamp
    logic signed [PROD_W-1:0]  s3_rnd [LANES];
    logic signed [PROD_W-1:0]  s3_q   [LANES];
    logic [LANES*OUT_W-1:0]    s3_data_d;
    logic                      s3_sat_d;
    logic [LANES*OUT_W-1:0]    s3_data_q;
    logic [CH_W-1:0]           s3_ch_q;
    logic                      s3_sat_q;

    always_comb begin
        s3_data_d = '0;
        s3_sat_d  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            s3_rnd[i] = s2_prod_q[i];
            if (s2_shift_q != '0) begin
                s3_rnd[i] = s2_prod_q[i] + (PROD_W'(1) << (s2_shift_q - 1'b1));
            end
            s3_q[i] = s3_rnd[i] >>> s2_shift_q;
            if (s3_q[i] > OUT_MAX) begin
                s3_data_d[i*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
                s3_sat_d = 1'b1;
            end else if (s3_q[i] < OUT_MIN) begin
                s3_data_d[i*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
                s3_sat_d = 1'b1;
            end else begin
                s3_data_d[i*OUT_W +: OUT_W] = s3_q[i][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_relu_q  <= 1'b0;
            s1_scale_q <= '0;
            s1_shift_q <= '0;
            s2_ch_q    <= '0;
            s2_shift_q <= '0;
            s3_ch_q    <= '0;
            s3_data_q  <= '0;
            s3_sat_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_sum_q[i]  <= '0;
                s2_prod_q[i] <= '0;
            end
        end else begin
            if (s1_load) begin
                s1_valid_q <= 1'b1;
                s1_ch_q    <= in_ch;
                s1_relu_q  <= relu_en;
                s1_scale_q <= scale_q[in_ch];
                s1_shift_q <= shift_q[in_ch];
                s1_sum_q   <= s1_sum_d;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_load) begin
                s2_valid_q <= 1'b1;
                s2_ch_q    <= s1_ch_q;
                s2_shift_q <= s1_shift_q;
                s2_prod_q  <= s2_prod_d;
            end else if (s3_load) begin
                s2_valid_q <= 1'b0;
            end
            if (s3_load) begin
                s3_valid_q <= 1'b1;
                s3_ch_q    <= s2_ch_q;
                s3_data_q  <= s3_data_d;
                s3_sat_q   <= s3_sat_d;
            end else if (out_ready) begin
                s3_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s3_valid_q;
    assign out_ch    = s3_ch_q;
    assign out_data  = s3_data_q;
    assign out_sat   = s3_sat_q;

endmodule
